// File: rtl/opc6_uart.sv
// opc6 I/O-space UART: 8N1 TX/RX with small FIFOs, baud divisor
// and an active-low level interrupt.
module opc6_uart #(
   parameter logic [15:0] BASE_ADDR  = 16'hFE00,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] DIV_RESET  = 16'd433
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clken,
   input  logic [15:0] address,
   input  logic [15:0] wdata,
   input  logic        rnw,
   input  logic        vio,
   output logic [15:0] rdata,
   output logic        int_b,
   output logic        txd,
   input  logic        rxd
);

   localparam int          PW   = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} st_e;

   logic          sel, acc;
   logic          wr_data, rd_data, rd_stat, wr_ctrl, wr_div;
   logic [1:0]    ctrl_q;
   logic [15:0]   div_q;
   logic          ovr_q, ovr_d, ferr_q, ferr_d, int_b_q, int_b_d;

   logic [7:0]    tx_mem [FIFO_DEPTH];
   logic [PW-1:0] tx_wp_q, tx_rp_q;
   logic [PW:0]   tx_cnt_q;
   logic          tx_push, tx_pop, tx_ne, tx_nf, tx_idle;

   logic [7:0]    rx_mem [FIFO_DEPTH];
   logic [PW-1:0] rx_wp_q, rx_rp_q;
   logic [PW:0]   rx_cnt_q;
   logic          rx_push, rx_pop, rx_ne, rx_nf;

   st_e           tx_st_q, rx_st_q;
   logic [15:0]   tx_tmr_q, rx_tmr_q;
   logic [2:0]    tx_bc_q, rx_bc_q;
   logic [7:0]    tx_sh_q, rx_sh_q;
   logic          txd_q, tx_tick, rx_tick;
   logic          rx_m_q, rx_s_q, rx_p_q;
   logic          rx_stop_smp, rx_good, rx_bad;

   assign sel     = vio && (address[15:2] == BASE_ADDR[15:2]);
   assign acc     = sel && clken;
   assign wr_data = acc && !rnw && (address[1:0] == 2'd0);
   assign rd_data = acc &&  rnw && (address[1:0] == 2'd0);
   assign rd_stat = acc &&  rnw && (address[1:0] == 2'd1);
   assign wr_ctrl = acc && !rnw && (address[1:0] == 2'd2);
   assign wr_div  = acc && !rnw && (address[1:0] == 2'd3);

   assign tx_ne   = tx_cnt_q != '0;
   assign tx_nf   = tx_cnt_q != FULL;
   assign rx_ne   = rx_cnt_q != '0;
   assign rx_nf   = rx_cnt_q != FULL;
   assign tx_tick = tx_tmr_q == 16'd0;
   assign rx_tick = rx_tmr_q == 16'd0;
   assign tx_idle = !tx_ne && (tx_st_q == S_IDLE);

   // Shifter reloads straight from STOP so back-to-back bytes have no gap
   assign tx_pop  = tx_ne &&
                    ((tx_st_q == S_IDLE) || (tx_st_q == S_STOP && tx_tick));
   assign tx_push = wr_data && tx_nf;

   assign rx_stop_smp = (rx_st_q == S_STOP) && rx_tick;
   assign rx_good     = rx_stop_smp && rx_s_q;
   assign rx_bad      = rx_stop_smp && !rx_s_q;
   assign rx_push     = rx_good && rx_nf;
   assign rx_pop      = rd_data && rx_ne;

   assign ovr_d   = (rx_good && !rx_nf) || (ovr_q && !rd_stat);
   assign ferr_d  = rx_bad || (ferr_q && !rd_stat);
   assign int_b_d = !((ctrl_q[0] && rx_ne) || (ctrl_q[1] && !tx_ne));

   always_comb begin
      rdata = 16'h0000;
      if (sel) begin
         unique case (address[1:0])
            2'd0: rdata = {8'h00, rx_ne ? rx_mem[rx_rp_q] : 8'h00};
            2'd1: rdata = {11'd0, ferr_q, tx_idle, ovr_q, tx_nf, rx_ne};
            2'd2: rdata = {14'd0, ctrl_q};
            2'd3: rdata = div_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_q  <= 2'b00;
         div_q   <= DIV_RESET;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
         int_b_q <= 1'b1;
      end else begin
         if (wr_ctrl) ctrl_q <= wdata[1:0];
         if (wr_div)  div_q  <= (wdata < 16'd2) ? 16'd1 : wdata;
         ovr_q   <= ovr_d;
         ferr_q  <= ferr_d;
         int_b_q <= int_b_d;
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp_q] <= wdata[7:0];
      if (rx_push) rx_mem[rx_wp_q] <= rx_sh_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_wp_q  <= '0;
         tx_rp_q  <= '0;
         tx_cnt_q <= '0;
         rx_wp_q  <= '0;
         rx_rp_q  <= '0;
         rx_cnt_q <= '0;
      end else begin
         if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
         if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
         tx_cnt_q <= tx_cnt_q + {{PW{1'b0}}, tx_push}
                              - {{PW{1'b0}}, tx_pop};
         if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
         if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
         rx_cnt_q <= rx_cnt_q + {{PW{1'b0}}, rx_push}
                              - {{PW{1'b0}}, rx_pop};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_st_q  <= S_IDLE;
         tx_tmr_q <= 16'd0;
         tx_bc_q  <= 3'd0;
         tx_sh_q  <= 8'h00;
         txd_q    <= 1'b1;
      end else begin
         unique case (tx_st_q)
            S_IDLE: begin
               txd_q <= 1'b1;
               if (tx_pop) begin
                  tx_st_q  <= S_START;
                  tx_sh_q  <= tx_mem[tx_rp_q];
                  tx_tmr_q <= div_q;
                  txd_q    <= 1'b0;
               end
            end
            S_START: begin
               if (tx_tick) begin
                  tx_st_q  <= S_DATA;
                  tx_bc_q  <= 3'd0;
                  tx_tmr_q <= div_q;
                  txd_q    <= tx_sh_q[0];
               end else begin
                  tx_tmr_q <= tx_tmr_q - 16'd1;
               end
            end
            S_DATA: begin
               if (tx_tick) begin
                  tx_tmr_q <= div_q;
                  if (tx_bc_q == 3'd7) begin
                     tx_st_q <= S_STOP;
                     txd_q   <= 1'b1;
                  end else begin
                     tx_bc_q <= tx_bc_q + 3'd1;
                     tx_sh_q <= {1'b0, tx_sh_q[7:1]};
                     txd_q   <= tx_sh_q[1];
                  end
               end else begin
                  tx_tmr_q <= tx_tmr_q - 16'd1;
               end
            end
            S_STOP: begin
               if (tx_tick) begin
                  if (tx_pop) begin
                     tx_st_q  <= S_START;
                     tx_sh_q  <= tx_mem[tx_rp_q];
                     tx_tmr_q <= div_q;
                     txd_q    <= 1'b0;
                  end else begin
                     tx_st_q <= S_IDLE;
                  end
               end else begin
                  tx_tmr_q <= tx_tmr_q - 16'd1;
               end
            end
         endcase
      end
   end

   // rx_p_q holds the previous synchronised level for edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_m_q   <= 1'b1;
         rx_s_q   <= 1'b1;
         rx_p_q   <= 1'b1;
         rx_st_q  <= S_IDLE;
         rx_tmr_q <= 16'd0;
         rx_bc_q  <= 3'd0;
         rx_sh_q  <= 8'h00;
      end else begin
         rx_m_q <= rxd;
         rx_s_q <= rx_m_q;
         rx_p_q <= rx_s_q;
         unique case (rx_st_q)
            S_IDLE: begin
               if (rx_p_q && !rx_s_q) begin
                  rx_st_q  <= S_START;
                  rx_tmr_q <= (div_q - 16'd1) >> 1;
               end
            end
            S_START: begin
               if (rx_tick) begin
                  rx_st_q  <= rx_s_q ? S_IDLE : S_DATA;
                  rx_bc_q  <= 3'd0;
                  rx_tmr_q <= div_q;
               end else begin
                  rx_tmr_q <= rx_tmr_q - 16'd1;
               end
            end
            S_DATA: begin
               if (rx_tick) begin
                  rx_sh_q  <= {rx_s_q, rx_sh_q[7:1]};
                  rx_tmr_q <= div_q;
                  if (rx_bc_q == 3'd7) rx_st_q <= S_STOP;
                  else                 rx_bc_q <= rx_bc_q + 3'd1;
               end else begin
                  rx_tmr_q <= rx_tmr_q - 16'd1;
               end
            end
            S_STOP: begin
               if (rx_tick) rx_st_q  <= S_IDLE;
               else         rx_tmr_q <= rx_tmr_q - 16'd1;
            end
         endcase
      end
   end

   assign txd   = txd_q;
   assign int_b = int_b_q;

endmodule
